// File: rtl/peripheral_sensor_acq.sv
// rtl/peripheral_sensor_acq.sv - debounced probe acquisition with counters, sticky flags and bus registers
// Optional irq output and IRQ_MASK register at 0x14 when SENSOR_IRQ_EN is defined.
module peripheral_sensor_acq #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    input  logic [1:0]  probe_in,
    output logic [1:0]  sensor_out
`ifdef SENSOR_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {STABLE = 1'b0, CHANGING = 1'b1} db_state_t;

    logic [3:0]       ctrl;
    logic             en;
    logic             mode;
    logic [1:0]       sync_q1;
    logic [1:0]       sync_q2;
    logic [1:0]       stable;
    logic [1:0]       rise;
    logic [1:0]       sticky;
    logic [CNT_W-1:0] evt_cnt [2];
    logic             wr_en;
    logic             rd_en;
    logic [2:0]       idx;
    logic [31:0]      rdata;
    logic [1:0]       irq_mask_val;
    logic             unused_ok;

    assign en        = ctrl[0];
    assign mode      = ctrl[1];
    assign wr_en     = cs & wr;
    assign rd_en     = cs & rd;
    assign idx       = addr[4:2];
    assign unused_ok = ^{addr[1:0], d_in[31:4]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= 2'b00;
            sync_q2 <= 2'b00;
        end else begin
            sync_q1 <= probe_in;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        db_state_t       state;
        db_state_t       state_nx;
        logic [DB_W-1:0] cnt;
        logic [DB_W-1:0] cnt_nx;
        logic [DB_W-1:0] cnt_inc;
        logic            stable_q;
        logic            stable_nx;

        assign stable[i] = stable_q;
        assign rise[i]   = stable_nx & ~stable_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state    <= STABLE;
                cnt      <= '0;
                stable_q <= 1'b0;
            end else begin
                state    <= state_nx;
                cnt      <= cnt_nx;
                stable_q <= stable_nx;
            end
        end

        // cnt_inc is the count this cycle would reach; hitting the limit commits the new level.
        always_comb begin
            state_nx  = state;
            cnt_nx    = cnt;
            stable_nx = stable_q;
            cnt_inc   = (state == STABLE) ? DB_W'(1) : cnt + DB_W'(1);
            if (!en) begin
                state_nx = STABLE;
                cnt_nx   = '0;
            end else if (sync_q2[i] == stable_q) begin
                state_nx = STABLE;
                cnt_nx   = '0;
            end else if (cnt_inc == DB_LAST) begin
                state_nx  = STABLE;
                cnt_nx    = '0;
                stable_nx = sync_q2[i];
            end else begin
                state_nx = CHANGING;
                cnt_nx   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl       <= 4'h0;
            sticky     <= 2'b00;
            evt_cnt[0] <= '0;
            evt_cnt[1] <= '0;
            d_out      <= 32'h0;
            sensor_out <= 2'b00;
        end else begin
            if (wr_en && idx == 3'd0)
                ctrl <= d_in[3:0];
            // Hardware set takes priority over a simultaneous write-one-to-clear.
            sticky <= (sticky & ~((wr_en && idx == 3'd2) ? d_in[1:0] : 2'b00)) | rise;
            for (int i = 0; i < 2; i++) begin
                if (wr_en && idx == 3'(3 + i))
                    evt_cnt[i] <= rise[i] ? CNT_W'(1) : '0;
                else if (rise[i] && evt_cnt[i] != CNT_MAX)
                    evt_cnt[i] <= evt_cnt[i] + CNT_W'(1);
            end
            if (rd_en)
                d_out <= rdata;
            sensor_out <= mode ? ctrl[3:2] : (en ? stable : 2'b00);
        end
    end

`ifdef SENSOR_IRQ_EN
    logic [1:0] irq_mask;

    assign irq_mask_val = irq_mask;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_mask <= 2'b00;
            irq      <= 1'b0;
        end else begin
            if (wr_en && idx == 3'd5)
                irq_mask <= d_in[1:0];
            irq <= |(sticky & irq_mask);
        end
    end
`else
    assign irq_mask_val = 2'b00;
`endif

    always_comb begin
        rdata = 32'h0;
        case (idx)
            3'd0:    rdata = {28'h0, ctrl};
            3'd1:    rdata = {28'h0, sync_q2, stable};
            3'd2:    rdata = {30'h0, sticky};
            3'd3:    rdata = 32'(evt_cnt[0]);
            3'd4:    rdata = 32'(evt_cnt[1]);
            3'd5:    rdata = {30'h0, irq_mask_val};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_peripheral_sensor_acq.sv
// tb/tb_peripheral_sensor_acq.sv - directed self-checking bench for peripheral_sensor_acq
module tb_peripheral_sensor_acq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic [1:0]  probe_in;
    logic [1:0]  sensor_out;
`ifdef SENSOR_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] r;

    always #5 clk = ~clk;

    peripheral_sensor_acq #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cs         (cs),
        .addr       (addr),
        .rd         (rd),
        .wr         (wr),
        .d_in       (d_in),
        .d_out      (d_out),
        .probe_in   (probe_in),
        .sensor_out (sensor_out)
`ifdef SENSOR_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] q);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        q = d_out;
    endtask

    initial begin
        resetn = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = 5'h0; d_in = 32'h0; probe_in = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_dout", d_out, 32'h0);
        check("rst_sensor", {30'h0, sensor_out}, 32'h0);

        // release reset while enabling acquisition in the first cycle
        resetn = 1'b1;
        bus_write(5'h00, 32'h1);
        @(negedge clk);
        bus_read(5'h04, r); check("status_sync_2clk", r, 32'hC);
        repeat (2) @(negedge clk);
        bus_read(5'h04, r); check("status_before_db", r, 32'hC);
        bus_read(5'h04, r); check("status_after_db", r, 32'hF);
        check("sensor_after_rst", {30'h0, sensor_out}, 32'h3);
        bus_read(5'h08, r); check("sticky_after_rst", r, 32'h3);
        bus_read(5'h0C, r); check("cnt0_after_rst", r, 32'h1);

        probe_in = 2'b00;
        repeat (10) @(negedge clk);
        bus_write(5'h0C, 32'h0);
        bus_write(5'h10, 32'h0);
        bus_write(5'h08, 32'h3);
        bus_read(5'h0C, r); check("cnt0_cleared", r, 32'h0);
        bus_read(5'h08, r); check("sticky_cleared", r, 32'h0);

        // 3-cycle glitch is rejected
        probe_in = 2'b01;
        repeat (3) @(negedge clk);
        probe_in = 2'b00;
        repeat (10) @(negedge clk);
        bus_read(5'h04, r); check("glitch_status", r, 32'h0);
        bus_read(5'h0C, r); check("glitch_cnt0", r, 32'h0);
        bus_read(5'h08, r); check("glitch_sticky", r, 32'h0);

        // 4-cycle pulse is accepted
        probe_in = 2'b01;
        repeat (4) @(negedge clk);
        probe_in = 2'b00;
        repeat (3) @(negedge clk);
        check("pulse_sensor", {30'h0, sensor_out}, 32'h1);
        bus_read(5'h04, r); check("pulse_status", r, 32'h1);
        repeat (8) @(negedge clk);
        bus_read(5'h0C, r); check("pulse_cnt0", r, 32'h1);
        bus_read(5'h08, r); check("pulse_sticky", r, 32'h1);
        bus_write(5'h08, 32'h1);

        for (int k = 0; k < 20; k++) begin
            probe_in = 2'b10;
            repeat (8) @(negedge clk);
            probe_in = 2'b00;
            repeat (8) @(negedge clk);
        end
        bus_read(5'h10, r); check("cnt1_saturated", r, 32'hF);
        bus_write(5'h10, 32'h0);
        bus_read(5'h10, r); check("cnt1_write_clear", r, 32'h0);

        // W1C lands on the same edge as the debounced rise
        probe_in = 2'b10;
        repeat (5) @(negedge clk);
        bus_write(5'h08, 32'h2);
        bus_read(5'h08, r); check("sticky_set_wins", r, 32'h2);
        bus_read(5'h10, r); check("cnt1_after_rise", r, 32'h1);
        probe_in = 2'b00;
        repeat (8) @(negedge clk);
        // counter clear lands on the same edge as the debounced rise
        probe_in = 2'b10;
        repeat (5) @(negedge clk);
        bus_write(5'h10, 32'h0);
        bus_read(5'h10, r); check("cnt1_clear_and_inc", r, 32'h1);

        probe_in = 2'b01;
        repeat (10) @(negedge clk);
        bus_write(5'h00, 32'hB);
        @(negedge clk);
        check("manual_sensor", {30'h0, sensor_out}, 32'h2);
        bus_read(5'h00, r); check("ctrl_readback", r, 32'hB);
        bus_write(5'h00, 32'h1);
        @(negedge clk);
        check("auto_sensor", {30'h0, sensor_out}, 32'h1);
        bus_write(5'h00, 32'h0);
        @(negedge clk);
        check("disabled_sensor", {30'h0, sensor_out}, 32'h0);
        probe_in = 2'b00;
        repeat (10) @(negedge clk);
        bus_read(5'h04, r); check("disabled_holds_stable", r, 32'h1);

        bus_write(5'h00, 32'h1);
        probe_in = 2'b11;
        repeat (10) @(negedge clk);
        bus_read(5'h18, r); check("unmapped_read", r, 32'h0);
        cs = 1'b1; rd = 1'b1; addr = 5'h04;
        #1;
        check("read_latency_before", d_out, 32'h0);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        check("read_latency_after", d_out, 32'hF);
        @(negedge clk);
        check("dout_holds", d_out, 32'hF);

`ifdef SENSOR_IRQ_EN
        probe_in = 2'b00;
        repeat (10) @(negedge clk);
        bus_write(5'h08, 32'h3);
        bus_write(5'h14, 32'h1);
        bus_read(5'h14, r); check("irq_mask_readback", r, 32'h1);
        check("irq_idle", {31'h0, irq}, 32'h0);
        probe_in = 2'b01;
        repeat (10) @(negedge clk);
        check("irq_on_ch0", {31'h0, irq}, 32'h1);
        bus_write(5'h08, 32'h1);
        @(negedge clk);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        probe_in = 2'b11;
        repeat (10) @(negedge clk);
        check("irq_masked_ch1", {31'h0, irq}, 32'h0);
        bus_read(5'h08, r); check("irq_sticky_ch1", r, 32'h2);
`else
        bus_write(5'h14, 32'h3);
        bus_read(5'h14, r); check("reg14_reads_zero", r, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
